// File: rtl/pingpong_buf_ctrl_pkg.sv
// Shared types and constants for the ping-pong buffer controller.
package pingpong_buf_ctrl_pkg;

  localparam int REP_WIDTH = 4;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

endpackage

// File: rtl/pingpong_skid_q.sv
// Two-entry output queue between the buffer read port and the consumer.
module pingpong_skid_q #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem_r [0:1];
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [1:0]            cnt_r;
  logic                  do_pop_s;

  assign do_pop_s = pop & (cnt_r != 2'd0);
  assign valid    = (cnt_r != 2'd0);
  assign data     = mem_r[rd_ptr_r];
  assign count    = cnt_r;

  // Pointer and occupancy tracking; the head entry never moves while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, do_pop_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Entry storage, data only.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong tile buffer controller: fills one bank while draining the other.
// Optional PINGPONG_BUF_CTRL_PERF_EN adds stall/starve performance counters.
module pingpong_buf_ctrl
  import pingpong_buf_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cfg_len,
  input  logic [REP_WIDTH-1:0]  cfg_rep,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  buf_wr_en,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [DATA_WIDTH-1:0] buf_wr_data,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [1:0]            bank_full
`ifdef PINGPONG_BUF_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_wr_stall,
  output logic [31:0]           perf_rd_starve
`endif
);

  localparam int CW = ADDR_WIDTH - 1;
  localparam int BANK_WORDS = 1 << CW;
  localparam logic [ADDR_WIDTH-1:0] LEN_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] LEN_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LEN_MAX  = ADDR_WIDTH'(BANK_WORDS);

  function automatic logic [ADDR_WIDTH-1:0] sat_len(input logic [ADDR_WIDTH-1:0] len);
    logic [ADDR_WIDTH-1:0] res;
    if (len == LEN_ZERO) begin
      res = LEN_ONE;
    end else if (len > LEN_MAX) begin
      res = LEN_MAX;
    end else begin
      res = len;
    end
    return res;
  endfunction

  bank_state_e           bank_st_r [0:1];
  logic [ADDR_WIDTH-1:0] len_r     [0:1];
  logic                  wbank_r;
  logic                  rbank_r;
  logic [CW-1:0]         wr_cnt_r;
  logic [CW-1:0]         rd_cnt_r;
  logic [REP_WIDTH-1:0]  pass_r;
  logic [REP_WIDTH-1:0]  rep_r;
  logic                  fl_v_r;
  logic                  fl_last_r;

  bank_state_e           wr_st_s;
  bank_state_e           rd_st_s;
  logic                  wr_fire_s;
  logic [ADDR_WIDTH-1:0] wr_len_s;
  logic                  wr_last_s;
  logic                  rd_sel_s;
  logic                  rd_act_s;
  logic [REP_WIDTH-1:0]  rd_rep_s;
  logic [2:0]            occ_s;
  logic                  issue_s;
  logic                  word_end_s;
  logic                  pass_end_s;
  logic                  final_s;
  logic                  pop_s;
  logic                  q_valid_s;
  logic [DATA_WIDTH:0]   q_data_s;
  logic [1:0]            q_count_s;

  // Write side: the length is frozen on a bank's first accepted word.
  assign wr_st_s     = bank_st_r[wbank_r];
  assign wr_ready    = (wr_st_s == EMPTY) || (wr_st_s == FILLING);
  assign wr_fire_s   = wr_valid & wr_ready & ~rst;
  assign wr_len_s    = (wr_st_s == EMPTY) ? sat_len(cfg_len) : len_r[wbank_r];
  assign wr_last_s   = ({1'b0, wr_cnt_r} == (wr_len_s - LEN_ONE));
  assign buf_wr_en   = wr_fire_s;
  assign buf_wr_addr = {wbank_r, wr_cnt_r};
  assign buf_wr_data = wr_data;

  // Read side: a FULL bank is issued from in the same cycle it is selected,
  // and the repeat count is taken live in that cycle.
  assign rd_st_s     = bank_st_r[rbank_r];
  assign rd_sel_s    = (rd_st_s == FULL);
  assign rd_act_s    = (rd_st_s == FULL) || (rd_st_s == DRAINING);
  assign rd_rep_s    = rd_sel_s ? cfg_rep : rep_r;
  assign pop_s       = q_valid_s & rd_ready;
  assign occ_s       = 3'(fl_v_r) + 3'(q_count_s) - 3'(pop_s);
  assign issue_s     = rd_act_s & (occ_s < 3'd2);
  assign word_end_s  = ({1'b0, rd_cnt_r} == (len_r[rbank_r] - LEN_ONE));
  assign pass_end_s  = (pass_r == rd_rep_s);
  assign final_s     = issue_s & word_end_s & pass_end_s;
  assign buf_rd_en   = issue_s;
  assign buf_rd_addr = {rbank_r, rd_cnt_r};

  assign bank_full[0] = (bank_st_r[0] == FULL) || (bank_st_r[0] == DRAINING);
  assign bank_full[1] = (bank_st_r[1] == FULL) || (bank_st_r[1] == DRAINING);

  // Per-bank state machines; writer and reader never own the same bank at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_st_r[0] <= EMPTY;
      bank_st_r[1] <= EMPTY;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_fire_s && (wbank_r == 1'(b))) begin
          bank_st_r[b] <= wr_last_s ? FULL : FILLING;
        end else if (final_s && (rbank_r == 1'(b))) begin
          bank_st_r[b] <= EMPTY;
        end else if (rd_sel_s && (rbank_r == 1'(b))) begin
          bank_st_r[b] <= DRAINING;
        end else begin
          bank_st_r[b] <= bank_st_r[b];
        end
      end
    end
  end

  // Write counter, bank pointer and latched tile length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank_r  <= 1'b0;
      wr_cnt_r <= '0;
      len_r[0] <= LEN_ONE;
      len_r[1] <= LEN_ONE;
    end else if (wr_fire_s) begin
      if (wr_st_s == EMPTY) begin
        len_r[wbank_r] <= wr_len_s;
      end
      if (wr_last_s) begin
        wr_cnt_r <= '0;
        wbank_r  <= ~wbank_r;
      end else begin
        wr_cnt_r <= wr_cnt_r + 1'b1;
      end
    end
  end

  // Read address/pass counters and the one-deep in-flight tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbank_r   <= 1'b0;
      rd_cnt_r  <= '0;
      pass_r    <= '0;
      rep_r     <= '0;
      fl_v_r    <= 1'b0;
      fl_last_r <= 1'b0;
    end else begin
      fl_v_r    <= issue_s;
      fl_last_r <= final_s;
      if (rd_sel_s) begin
        rep_r <= cfg_rep;
      end
      if (issue_s) begin
        if (word_end_s) begin
          rd_cnt_r <= '0;
          if (pass_end_s) begin
            pass_r  <= '0;
            rbank_r <= ~rbank_r;
          end else begin
            pass_r <= pass_r + 1'b1;
          end
        end else begin
          rd_cnt_r <= rd_cnt_r + 1'b1;
        end
      end
    end
  end

  pingpong_skid_q #(
    .DATA_WIDTH(DATA_WIDTH + 1)
  ) u_skid_q (
    .clk       (clk),
    .rst       (rst),
    .push      (fl_v_r),
    .push_data ({fl_last_r, buf_rd_data}),
    .pop       (pop_s),
    .valid     (q_valid_s),
    .data      (q_data_s),
    .count     (q_count_s)
  );

  assign rd_valid = q_valid_s;
  assign rd_data  = q_data_s[DATA_WIDTH-1:0];
  assign rd_last  = q_valid_s & q_data_s[DATA_WIDTH];

`ifdef PINGPONG_BUF_CTRL_PERF_EN
  // Saturating producer-stall and consumer-starve counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_wr_stall  <= 32'd0;
      perf_rd_starve <= 32'd0;
    end else begin
      if (wr_valid && !wr_ready && (perf_wr_stall != 32'hFFFF_FFFF)) begin
        perf_wr_stall <= perf_wr_stall + 32'd1;
      end
      if (rd_ready && !rd_valid && (perf_rd_starve != 32'hFFFF_FFFF)) begin
        perf_rd_starve <= perf_rd_starve + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Self-checking bench for pingpong_buf_ctrl: cycle model plus directed scenarios.
module tb_pingpong_buf_ctrl;

  localparam int AW = 8;
  localparam int DW = 64;
  localparam int BW = 128;

  logic          clk;
  logic          rst;
  logic [AW-1:0] cfg_len;
  logic [3:0]    cfg_rep;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic [DW-1:0] buf_wr_data;
  logic          buf_rd_en;
  logic [AW-1:0] buf_rd_addr;
  logic [DW-1:0] buf_rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic [1:0]    bank_full;
`ifdef PINGPONG_BUF_CTRL_PERF_EN
  logic [31:0]   perf_wr_stall;
  logic [31:0]   perf_rd_starve;
`endif

  pingpong_buf_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_rep(cfg_rep),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .bank_full(bank_full)
`ifdef PINGPONG_BUF_CTRL_PERF_EN
    , .perf_wr_stall(perf_wr_stall), .perf_rd_starve(perf_rd_starve)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Buffer memory seen by the DUT
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (buf_wr_en) ram[buf_wr_addr] <= buf_wr_data;
    if (buf_rd_en) buf_rd_data <= ram[buf_rd_addr];
  end

  // Model state: phase 0 empty, 1 filling, 2 full, 3 draining
  int          m_phase [2];
  int          m_len   [2];
  int          m_rep   [2];
  int          m_wbank, m_wcnt, m_rbank, m_ridx;
  logic [DW-1:0] m_mem [0:255];
  logic [64:0] m_q [$];
  bit          m_fl_v;
  logic [64:0] m_fl;

  logic [63:0] pop_data_q [$];
  bit          pop_last_q [$];
  int          n_issue;
  bit          prev_stall;
  logic [63:0] prev_data;

  int  e_waddr, e_raddr, tot;
  bit  e_wr_ready, e_wr_fire, e_rv, e_pop, e_issue;

  function automatic int sat(input int x);
    if (x == 0) return 1;
    else if (x > BW) return BW;
    else return x;
  endfunction

  // Compare DUT against the model every cycle, then advance the model
  always @(negedge clk) begin
    if (rst) begin
      m_phase[0] = 0; m_phase[1] = 0; m_len[0] = 1; m_len[1] = 1;
      m_wbank = 0; m_wcnt = 0; m_rbank = 0; m_ridx = 0;
      m_q.delete(); m_fl_v = 1'b0;
    end
    e_wr_ready = (m_phase[m_wbank] <= 1);
    e_wr_fire  = wr_valid && e_wr_ready && !rst;
    e_waddr    = m_wbank * BW + m_wcnt;
    e_rv       = (m_q.size() != 0);
    e_pop      = e_rv && rd_ready;
    e_issue    = !rst && (m_phase[m_rbank] >= 2) &&
                 ((int'(m_fl_v) + m_q.size() - int'(e_pop)) < 2);
    e_raddr    = m_rbank * BW + (m_ridx % m_len[m_rbank]);

    chk("wr_ready", 64'(wr_ready), 64'(e_wr_ready));
    chk("buf_wr_en", 64'(buf_wr_en), 64'(e_wr_fire));
    if (e_wr_fire) begin
      chk("buf_wr_addr", 64'(buf_wr_addr), 64'(e_waddr));
      chk("buf_wr_data", buf_wr_data, wr_data);
    end
    chk("bank_full", 64'(bank_full), 64'({m_phase[1] >= 2, m_phase[0] >= 2}));
    chk("rd_valid", 64'(rd_valid), 64'(e_rv));
    chk("rd_last", 64'(rd_last), e_rv ? 64'(m_q[0][64]) : 64'd0);
    if (e_rv) chk("rd_data", rd_data, m_q[0][63:0]);
    chk("buf_rd_en", 64'(buf_rd_en), 64'(e_issue));
    if (e_issue) chk("buf_rd_addr", 64'(buf_rd_addr), 64'(e_raddr));
    if (!rst && prev_stall && rd_valid) chk("rd_data_hold", rd_data, prev_data);

    prev_stall = !rst && rd_valid && !rd_ready;
    prev_data  = rd_data;
    if (!rst && rd_valid && rd_ready) begin
      pop_data_q.push_back(rd_data);
      pop_last_q.push_back(rd_last);
    end
    if (!rst && buf_rd_en) n_issue++;

    if (!rst) begin
      if (e_pop) void'(m_q.pop_front());
      if (m_fl_v) m_q.push_back(m_fl);
      m_fl_v = 1'b0;
      if (m_phase[m_rbank] == 2) begin
        m_rep[m_rbank]   = int'(cfg_rep);
        m_phase[m_rbank] = 3;
      end
      if (e_issue) begin
        tot    = m_len[m_rbank] * (m_rep[m_rbank] + 1);
        m_fl   = {m_ridx == tot - 1, m_mem[e_raddr]};
        m_fl_v = 1'b1;
        m_ridx++;
        if (m_ridx == tot) begin
          m_phase[m_rbank] = 0;
          m_rbank = 1 - m_rbank;
          m_ridx  = 0;
        end
      end
      if (e_wr_fire) begin
        if (m_phase[m_wbank] == 0) m_len[m_wbank] = sat(int'(cfg_len));
        m_mem[e_waddr] = wr_data;
        m_phase[m_wbank] = 1;
        m_wcnt++;
        if (m_wcnt == m_len[m_wbank]) begin
          m_phase[m_wbank] = 2;
          m_wcnt  = 0;
          m_wbank = 1 - m_wbank;
        end
      end
    end
  end

  // Consumer ready pattern generator
  int rd_mode = 0;
  initial begin
    int ph = 0;
    logic [3:0] pat;
    pat = 4'b1001;
    rd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rd_mode)
        0: rd_ready = 1'b1;
        1: rd_ready = 1'b0;
        default: begin
          rd_ready = pat[3 - (ph % 4)];
          ph++;
        end
      endcase
    end
  end

  int wlog [$];

  task automatic reset_dut();
    rst = 1'b1;
    wr_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    pop_data_q.delete(); pop_last_q.delete(); wlog.delete();
    n_issue = 0;
  endtask

  task automatic write_words(input int n, input logic [63:0] base, input int budget,
                             output int acc, output int stalls);
    int c = 0;
    acc = 0; stalls = 0;
    while (acc < n && c < budget) begin
      wr_valid = 1'b1;
      wr_data  = base + 64'(acc);
      @(negedge clk);
      if (wr_ready) begin
        wlog.push_back(int'(buf_wr_addr));
        acc++;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
      c++;
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    bit idle = 1'b0;
    while (!idle && c < budget) begin
      @(posedge clk); #1;
      c++;
      idle = (m_phase[0] == 0) && (m_phase[1] == 0) && (m_q.size() == 0) && !m_fl_v;
    end
    chk("drain_done", 64'(idle), 64'd1);
  endtask

  function automatic int count_last();
    int k = 0;
    foreach (pop_last_q[i]) if (pop_last_q[i]) k++;
    return k;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, st;
    logic [63:0] exp_v;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; cfg_len = 8'd4; cfg_rep = 4'd0;
    @(negedge clk);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_bank_full", 64'(bank_full), 64'd0);
    chk("rst_rd_en", 64'(buf_rd_en), 64'd0);

    // basic
    reset_dut();
    rd_mode = 0; cfg_len = 8'd4; cfg_rep = 4'd0;
    write_words(4, 64'd1, 20, acc, st);
    wait_idle(100);
    chk("basic_nwr", 64'(wlog.size()), 64'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) chk("basic_waddr", 64'(wlog[i]), 64'(i));
    chk("basic_npop", 64'(pop_data_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < pop_data_q.size(); i++) begin
      chk("basic_rdata", pop_data_q[i], 64'(i + 1));
      chk("basic_last", 64'(pop_last_q[i]), 64'(i == 3));
    end
    @(negedge clk);
    chk("basic_bank_full", 64'(bank_full), 64'd0);

    // ping-pong
    reset_dut();
    cfg_len = 8'd8; cfg_rep = 4'd0;
    write_words(16, 64'h100, 40, acc, st);
    chk("pp_acc", 64'(acc), 64'd16);
    chk("pp_stalls", 64'(st), 64'd0);
    for (int i = 8; i < 16 && i < wlog.size(); i++) chk("pp_waddr", 64'(wlog[i]), 64'(120 + i));
    wait_idle(200);
    chk("pp_npop", 64'(pop_data_q.size()), 64'd16);

    // both full
    reset_dut();
    rd_mode = 1; cfg_len = 8'd2; cfg_rep = 4'd2;
    write_words(6, 64'h200, 12, acc, st);
    chk("bf_acc", 64'(acc), 64'd4);
    @(negedge clk);
    chk("bf_wr_ready", 64'(wr_ready), 64'd0);
    chk("bf_bank_full", 64'(bank_full), 64'd3);
    chk("bf_issue", 64'(n_issue), 64'd2);
    rd_mode = 0;
    write_words(2, 64'h204, 200, acc, st);
    wait_idle(300);
    chk("bf_npop", 64'(pop_data_q.size()), 64'd18);
    chk("bf_nlast", 64'(count_last()), 64'd3);

    // backpressure
    reset_dut();
    rd_mode = 2; cfg_len = 8'd4; cfg_rep = 4'd1;
    write_words(8, 64'h10, 200, acc, st);
    wait_idle(400);
    chk("bp_npop", 64'(pop_data_q.size()), 64'd16);
    for (int k = 0; k < 16 && k < pop_data_q.size(); k++) begin
      exp_v = 64'h10 + 64'((k / 8) * 4 + (k % 4));
      chk("bp_rdata", pop_data_q[k], exp_v);
    end
    chk("bp_nlast", 64'(count_last()), 64'd2);
    rd_mode = 0;

    // mid-reset
    reset_dut();
    cfg_len = 8'd4; cfg_rep = 4'd0;
    write_words(2, 64'h300, 10, acc, st);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_wr_ready", 64'(wr_ready), 64'd1);
    chk("mr_rd_valid", 64'(rd_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wlog.delete(); pop_data_q.delete(); pop_last_q.delete();
    write_words(4, 64'h400, 20, acc, st);
    chk("mr_first_addr", (wlog.size() > 0) ? 64'(wlog[0]) : 64'hDEAD, 64'd0);
    wait_idle(100);
    chk("mr_npop", 64'(pop_data_q.size()), 64'd4);

    // length saturation
    reset_dut();
    cfg_len = 8'd0; cfg_rep = 4'd0;
    write_words(1, 64'h55, 10, acc, st);
    wait_idle(50);
    chk("len0_npop", 64'(pop_data_q.size()), 64'd1);
    chk("len0_last", 64'(count_last()), 64'd1);
    reset_dut();
    cfg_len = 8'd200;
    write_words(128, 64'h1000, 300, acc, st);
    chk("len200_last_addr", (wlog.size() == 128) ? 64'(wlog[127]) : 64'hDEAD, 64'd127);
    wait_idle(400);
    chk("len200_npop", 64'(pop_data_q.size()), 64'd128);
    chk("len200_final", (pop_last_q.size() == 128) ? 64'(pop_last_q[127]) : 64'd0, 64'd1);
    chk("len200_nlast", 64'(count_last()), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pingpong_buf_ctrl.md
PINGPONG_BUF_CTRL -- requirements
Module: pingpong_buf_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, buffer address width; the MSB selects the bank, so each bank holds 2^(ADDR_WIDTH-1) words.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, word width.
REQ-003 SHALL have these ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_len  in  ADDR_WIDTH  tile length in words, legal 1..2^(ADDR_WIDTH-1); sampled on a bank's first accepted write.
- cfg_rep  in  4  read passes per tile, minus 1; sampled when a bank starts draining.
- wr_valid / wr_ready  in / out  1  producer handshake.
- wr_data  in  DATA_WIDTH  producer word.
- buf_wr_en, buf_wr_addr, buf_wr_data  out  1 / ADDR_WIDTH / DATA_WIDTH  buffer write port.
- buf_rd_en, buf_rd_addr  out  1 / ADDR_WIDTH  buffer read port.
- buf_rd_data  in  DATA_WIDTH  buffer read data, valid the cycle after buf_rd_en.
- rd_valid / rd_ready  out / in  1  consumer handshake.
- rd_data  out  DATA_WIDTH  consumer word.
- rd_last  out  1  last word of the last pass of a tile.
- bank_full  out  2  per-bank FULL or DRAINING status.

Function
REQ-004 Each bank SHALL have a state machine: EMPTY -> FILLING on the first accepted write; FILLING -> FULL on the write of word cfg_len-1; FULL -> DRAINING when the reader selects it; DRAINING -> EMPTY in the cycle after the final read issue.
REQ-005 wr_ready SHALL be 1 only when the write bank is EMPTY or FILLING.
REQ-006 On wr_valid&wr_ready, the block SHALL drive buf_wr_en=1, buf_wr_addr={wbank,cnt}, buf_wr_data=wr_data in the same cycle (combinational pass-through).
REQ-007 The write bank SHALL toggle on the transition to FULL.
REQ-008 The reader SHALL serve banks strictly alternately, starting with bank 0.
REQ-009 The reader SHALL issue addresses {rbank,0..len-1} in order, cfg_rep+1 passes.
REQ-010 A read SHALL be issued only when the words in flight plus the words queued are fewer than 2.
REQ-011 Read data SHALL enter a 2-entry output queue the cycle after issue; rd_valid means the queue is non-empty.
REQ-012 Throughput SHALL be one word per cycle while rd_ready=1.
REQ-013 The minimum latency from the FULL transition to rd_valid SHALL be 2 cycles.
REQ-014 rd_data SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-015 rd_last SHALL be asserted with word len-1 of pass cfg_rep only.
REQ-016 Simultaneous write and read on opposite banks SHALL both proceed.
REQ-017 A bank released in cycle N SHALL accept its first write no earlier than cycle N+1.
REQ-018 cfg_len=0 SHALL be treated as 1; values above 2^(ADDR_WIDTH-1) SHALL saturate to 2^(ADDR_WIDTH-1).

Reset
REQ-019 On rst: both banks EMPTY, wbank=rbank=0, all counters 0, queue empty.
REQ-020 Output values during and after rst SHALL be: wr_ready=1, rd_valid=0, rd_last=0, buf_wr_en=0, buf_rd_en=0, bank_full=0.
REQ-021 Reset mid-tile SHALL discard all partial and full tiles; buffer contents are not cleared.

Configuration
REQ-022 With PINGPONG_BUF_CTRL_PERF_EN defined, the block SHALL add two 32-bit saturating outputs:
- perf_wr_stall: cycles with wr_valid&!wr_ready.
- perf_rd_starve: cycles with rd_ready&!rd_valid.
Both SHALL reset to 0.
REQ-023 Without PINGPONG_BUF_CTRL_PERF_EN, those ports and their logic SHALL be absent.

Structure
REQ-024 Package pingpong_buf_ctrl_pkg SHALL hold the bank-state enum (EMPTY, FILLING, FULL, DRAINING) and the constant REP_WIDTH=4.
REQ-025 The 2-entry output queue SHALL be sub-module pingpong_skid_q (parameter DATA_WIDTH).

Verification
REQ-026 Scenario basic: cfg_len=4, cfg_rep=0, write words 1..4, rd_ready=1 -> buf addresses 0..3; rd_data 1,2,3,4; rd_last on word 4; bank_full returns to 00.
REQ-027 Scenario ping-pong: continuous writes of two tiles, len=8 -> the second tile goes to addresses 128..135 while the first drains; wr_ready never drops with rd_ready=1.
REQ-028 Scenario both full: cfg_rep=2, len=2, three tiles written, rd_ready=0 -> wr_ready=0 after 4 writes; bank_full=11; no buf_rd_en beyond 2 outstanding.
REQ-029 Scenario backpressure: rd_ready toggling 1,0,0,1 -> no word lost or duplicated; rd_data stable while stalled.
REQ-030 Scenario mid-reset: rst asserted after 2 of 4 words written -> next cycle wr_ready=1, rd_valid=0; the next tile starts at address 0.
REQ-031 Scenario cfg_len=0 and cfg_len=200 -> treated as 1 word and 128 words respectively.
